apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL provide parameter DATA_W, default 32, APB data width.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN; range 2..255).
REQ-004 SHALL have ports:
  PCLK  in  1  clock, all logic on rising edge
  PRESETn  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  ADDR_W  transfer address
  cmd_wdata  in  DATA_W  write data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  DATA_W  read data
  rsp_err  out  1  transfer error
  PSELx  out  1  APB select
  PENABLE  out  1  APB enable
  PWRITE  out  1  APB direction
  PADDR  out  ADDR_W  APB address
  PWDATA  out  DATA_W  APB write data
  PRDATA  in  DATA_W  APB read data
  PREADY  in  1  APB slave ready
  PSLVERR  in  1  APB slave error

Function
REQ-005 SHALL implement FSM with states IDLE, SETUP, ACCESS; all outputs except cmd_ready registered.
REQ-006 SHALL drive cmd_ready=1 only in IDLE (decoded from state, no combinational path from cmd_valid).
REQ-007 IDLE: on cmd_valid=1 SHALL capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, set PSELx=1, PENABLE=0, next state SETUP.
REQ-008 SETUP: SHALL last exactly one cycle, then set PENABLE=1, next state ACCESS.
REQ-009 ACCESS: SHALL hold PSELx=1, PENABLE=1, PWRITE, PADDR, PWDATA stable until PREADY=1 sampled at a rising edge.
REQ-010 On PREADY=1 in ACCESS SHALL: clear PSELx and PENABLE, pulse rsp_valid=1 for one cycle, set rsp_err=PSLVERR, next state IDLE.
REQ-011 On read completion SHALL load rsp_rdata=PRDATA; on write completion rsp_rdata=0.
REQ-012 SHALL ignore PRDATA and PSLVERR whenever PREADY=0 or state is not ACCESS.
REQ-013 SHALL drive PWDATA=0 for read transfers.
REQ-014 PADDR and PWRITE SHALL hold last transfer value in IDLE; rsp_rdata/rsp_err SHALL hold until next completion.
REQ-015 Minimum transfer: accept edge -> SETUP 1 cycle -> ACCESS >=1 cycle -> rsp_valid in cycle after PREADY sampled; next command accepted in that same rsp_valid cycle (back-to-back gap: one IDLE cycle with PSELx=0).
REQ-016 cmd_valid while not in IDLE SHALL have no effect; command inputs are sampled only at the accept edge.

Reset
REQ-017 PRESETn=0 SHALL asynchronously force state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
REQ-018 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid generated.

Configuration
REQ-019 With macro APB_MASTER_TIMEOUT_EN defined, SHALL count ACCESS cycles; if TIMEOUT_CYCLES ACCESS cycles elapse with PREADY=0, SHALL clear PSELx/PENABLE, pulse rsp_valid with rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-020 PREADY=1 on the final allowed cycle SHALL complete normally (completion wins over timeout).
REQ-021 Without APB_MASTER_TIMEOUT_EN, no counter SHALL be instantiated and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-022 Write cmd_addr=0x10, cmd_wdata=0xDEADBEEF, slave PREADY in first ACCESS cycle -> PSELx 2 cycles, PENABLE 1 cycle, rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-023 Read cmd_addr=0x13, slave 3 wait cycles, PRDATA=0x12345678 -> PADDR/PWRITE stable 5 cycles, rsp_rdata=0x12345678, rsp_err=0.
REQ-024 Read with PSLVERR=1 and PREADY=1 -> rsp_valid=1, rsp_err=1; PSLVERR=1 with PREADY=0 -> ignored.
REQ-025 cmd_valid held high for 3 commands -> cmd_ready pulses once per transfer, exactly one IDLE cycle between PSELx windows, responses in order.
REQ-026 PRESETn low in ACCESS -> all outputs 0 immediately, no rsp_valid; next command after release completes normally.
REQ-027 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1; PREADY=1 in 4th cycle -> normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: converts single-beat commands into APB SETUP/ACCESS transfers.
// Each command is answered with a one-cycle rsp_valid pulse that carries the
// read data and the slave error flag.
// Optional build macro APB_MASTER_TIMEOUT_EN: aborts an ACCESS phase that has
// seen no PREADY for TIMEOUT_CYCLES cycles, answering with rsp_err=1.
//
// state  | meaning
// IDLE   | no transfer in flight, cmd_ready high, PSELx low
// SETUP  | first APB cycle, PSELx high, PENABLE low
// ACCESS | PSELx and PENABLE high, waiting for PREADY (or timeout)
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  // Down-counter of remaining ACCESS cycles; zero means this is the last one.
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = (tmo_cnt_q == 8'd0);
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output decode; registers hold unless a state acts.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = 8'(TIMEOUT_CYCLES - 1);
`endif
      end
      ACCESS: begin
        // Completion is checked first so PREADY on the last allowed cycle wins.
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = IDLE;
        end else if (tmo_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q - 8'd1;
`endif
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed transfers against apb_master with a scripted slave.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int          o_psel, o_pen;
  logic        o_stable, o_busy_rdy, o_setup_ok, o_start_ok;
  logic        o_rv, o_re;
  logic [31:0] o_rd;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer, entered and left at posedge+1. The slave inserts `waits`
  // wait states with junk PRDATA/PSLVERR=1, then answers with rdata/slverr.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input logic slverr,
                      input logic hold_valid);
    int acc = 0;
    int cyc = 0;
    logic [31:0] exp_wd;
    exp_wd = wr ? wdata : 32'h0;
    o_psel = 0; o_pen = 0; o_stable = 1'b1; o_busy_rdy = 1'b0;
    o_start_ok = (cmd_ready === 1'b1) && (PSELx === 1'b0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge PCLK); #1;
    if (!hold_valid) cmd_valid = 1'b0;
    cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
    o_setup_ok = (PSELx === 1'b1) && (PENABLE === 1'b0);
    while (rsp_valid !== 1'b1 && cyc < 60) begin
      if (PSELx === 1'b1) o_psel++;
      if (PENABLE === 1'b1) o_pen++;
      if (cmd_ready !== 1'b0) o_busy_rdy = 1'b1;
      if (PSELx === 1'b1 && (PADDR !== addr || PWRITE !== wr || PWDATA !== exp_wd)) o_stable = 1'b0;
      if (PENABLE === 1'b1) acc++;
      if (PENABLE === 1'b1 && acc > waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end else begin
        PREADY = 1'b0; PRDATA = 32'hBAD0_0000 + 32'(cyc); PSLVERR = 1'b1;
      end
      @(posedge PCLK); #1;
      cyc++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_FFFF;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    o_rv = rsp_valid; o_rd = rsp_rdata; o_re = rsp_err;
    chk("psel_after_done", {63'h0, PSELx}, 64'h0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ctrl", {58'h0, PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, 64'h1);
    chk("rst_addr_wdata", {PADDR, PWDATA}, 64'h0);
    chk("rst_rdata", {32'h0, rsp_rdata}, 64'h0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // single write, zero wait states
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
    chk("wr_start", {63'h0, o_start_ok}, 64'h1);
    chk("wr_setup", {63'h0, o_setup_ok}, 64'h1);
    chk("wr_psel_cycles", 64'(o_psel), 64'd2);
    chk("wr_pen_cycles", 64'(o_pen), 64'd1);
    chk("wr_stable", {63'h0, o_stable}, 64'h1);
    chk("wr_busy_ready", {63'h0, o_busy_rdy}, 64'h0);
    chk("wr_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0});
    @(posedge PCLK); #1;
    chk("wr_rsp_pulse", {63'h0, rsp_valid}, 64'h0);

    // read with three wait states
    xfer(1'b0, 32'h13, 32'hCAFEF00D, 3, 32'h12345678, 1'b0, 1'b0);
    chk("rd_psel_cycles", 64'(o_psel), 64'd5);
    chk("rd_stable", {63'h0, o_stable}, 64'h1);
    chk("rd_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h12345678});
    @(posedge PCLK); #1;
    chk("idle_hold_addr", {31'h0, PWRITE, PADDR}, {31'h0, 1'b0, 32'h13});
    chk("idle_hold_rsp", {31'h0, rsp_err, rsp_rdata}, {31'h0, 1'b0, 32'h12345678});

    // slave error with PREADY completes as error
    xfer(1'b0, 32'h24, 32'h0, 1, 32'h0000_00E1, 1'b1, 1'b0);
    chk("err_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b1, 32'h0000_00E1});
    // PSLVERR asserted only during wait states is ignored
    xfer(1'b0, 32'h28, 32'h0, 2, 32'h0000_0ABC, 1'b0, 1'b0);
    chk("err_ignored", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0000_0ABC});
    @(posedge PCLK); #1;

    // three back-to-back commands with cmd_valid held
    xfer(1'b0, 32'h100, 32'h0, 0, 32'h0000_00A1, 1'b0, 1'b1);
    chk("b2b0_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0000_00A1});
    chk("b2b0_psel", 64'(o_psel), 64'd2);
    xfer(1'b1, 32'h104, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b1);
    chk("b2b1_gap", {62'h0, o_start_ok, o_setup_ok}, 64'h3);
    chk("b2b1_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0});
    xfer(1'b0, 32'h108, 32'h0, 1, 32'h0000_00C3, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    chk("b2b2_gap", {62'h0, o_start_ok, o_setup_ok}, 64'h3);
    chk("b2b2_psel", 64'(o_psel), 64'd3);
    chk("b2b2_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0000_00C3});
    @(posedge PCLK); #1;
    chk("b2b_idle", {62'h0, PSELx, rsp_valid}, 64'h0);

    // reset while in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55AA55AA;
    @(posedge PCLK); #1; cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    chk("rst_pre_access", {61'h0, PSELx, PENABLE, PWRITE}, 64'h7);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_async_ctrl", {59'h0, PSELx, PENABLE, PWRITE, rsp_valid, rsp_err}, 64'h0);
    chk("rst_async_bus", {PADDR, PWDATA}, 64'h0);
    chk("rst_async_rdata", {32'h0, rsp_rdata}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      chk("rst_no_rsp", {63'h0, rsp_valid}, 64'h0);
    end
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_release_no_rsp", {63'h0, rsp_valid}, 64'h0);
    xfer(1'b0, 32'h30, 32'h0, 1, 32'h0BADCAFE, 1'b0, 1'b0);
    chk("post_rst_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0BADCAFE});
    chk("post_rst_psel", 64'(o_psel), 64'd3);
    @(posedge PCLK); #1;

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY never comes: abort after four ACCESS cycles
    xfer(1'b0, 32'h40, 32'h0, 1000, 32'h0, 1'b0, 1'b0);
    chk("tmo_pen_cycles", 64'(o_pen), 64'd4);
    chk("tmo_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b1, 32'h0});
    @(posedge PCLK); #1;
    // PREADY on the fourth ACCESS cycle completes normally
    xfer(1'b0, 32'h44, 32'h0, 3, 32'h0000_4444, 1'b0, 1'b0);
    chk("tmo_last_pen", 64'(o_pen), 64'd4);
    chk("tmo_last_rsp", {30'h0, o_rv, o_re, o_rd}, {30'h0, 1'b1, 1'b0, 32'h0000_4444});
    @(posedge PCLK); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
